arbiter_game_fsm_multi: RTL
===========================

# arbiter_game_fsm_multi

Parametrised, multi-player, multi-round successor to the two-player reaction-game controller. It sequences countdown, first-press grant, winner display and game end for `N_PLAYERS` players over `N_ROUNDS` rounds, and keeps per-player scores. It can optionally disqualify players who press during the countdown. It sits between the debounced player buttons and the countdown, winner-timer and LED driver blocks.

## Interface
Parameters:
- `N_PLAYERS`, default 4: number of players, 2..8; `IDX_W = $clog2(N_PLAYERS)`.
- `N_ROUNDS`, default 3: rounds per game, 1..15; `SC_W = $clog2(N_ROUNDS+1)`.

Ports (the only clock is `clk`; reset `rst_in_n` is asynchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge.
- `rst_in_n`  in  1  asynchronous active-low reset.
- `req`  in  N_PLAYERS  player buttons, active-high, synchronised upstream.
- `cd_done`  in  1  countdown finished.
- `w_done`  in  1  winner display time elapsed.
- `gnt_out`  out  N_PLAYERS  one-hot grant to the current round winner.
- `cd_rst_out`  out  1  countdown block reset.
- `w_rst_out`  out  1  winner timer reset.
- `leds_rst_out`  out  1  LED driver reset.
- `leds_sel_out`  out  1  LED source select; 1 = winner pattern.
- `winner_idx_out`  out  IDX_W  round winner index or champion index.
- `round_out`  out  SC_W  number of completed rounds.
- `score_out`  out  N_PLAYERS*SC_W  flat scores; player i occupies `[i*SC_W +: SC_W]`.
- `dq_out`  out  N_PLAYERS  players disqualified in the current round.
- `game_over_out`  out  1  high in GAME_END.

## Operation
- Moore FSM states: RESET, COUNTDOWN, IDLE, GNT, WINNER, GAME_END. Any illegal encoding returns to RESET on the next clock.
- RESET: always goes to COUNTDOWN next cycle. Clears `dq` and the latched round winner index.
- COUNTDOWN: goes to IDLE on `cd_done`. With false-start detection compiled in, any `req[i]` sampled high here sets `dq[i]`.
- IDLE: masked requests are `req & ~dq`.
  - Exactly one masked bit high: latch its index and go to GNT.
  - Zero, or two or more, bits high (a tie): stay in IDLE.
  - If `dq` is all ones: go to RESET; the round is replayed and not counted.
- GNT: stay while `req[idx]` is held. On release, go to WINNER and increment `score[idx]` on that transition.
- WINNER: on `w_done`, increment `round_out`.
  - If the new round count equals `N_ROUNDS`, go to GAME_END.
  - Otherwise go to RESET to start the next round. Scores and round count persist.
- GAME_END: terminal until reset. Champion is the highest score; the lowest index wins a tie. The champion is registered on entry.
- Outputs per state as (cd_rst, w_rst, leds_rst, leds_sel):
  - RESET, IDLE and GAME_END: 1, 1, 1, 0.
  - COUNTDOWN: 0, 1, 0, 0.
  - GNT and WINNER: 1, 0, 0, 1.
- `gnt_out` is one-hot of the latched index in GNT and WINNER, otherwise 0.
- `winner_idx_out` is the latched index in GNT and WINNER, the champion in GAME_END, otherwise 0.
- Scores never exceed `N_ROUNDS`, so no saturation logic is needed.

## Timing
- Reset values: state RESET; `gnt_out` 0; `cd_rst_out`, `w_rst_out` and `leds_rst_out` 1; `leds_sel_out` 0; `winner_idx_out`, `round_out`, `score_out` and `dq_out` 0; `game_over_out` 0.
- Outputs decode directly from registered state and registers, with no extra output stage.
- `gnt_out` rises one clock after the edge that samples the single masked request.
- Release to WINNER takes one clock. The score is visible in the same cycle that WINNER is entered.
- `dq` bits set one clock after a COUNTDOWN sample.
- Asserting `rst_in_n` low at any point immediately clears all state, including scores and round count.

## Configuration
- `ARB_FALSE_START_EN` defined: COUNTDOWN presses set `dq`, disqualified players are masked in IDLE, and the all-disqualified replay path is active.
- `ARB_FALSE_START_EN` undefined: `dq` is held at 0 and `dq_out` is tied to 0. Masked requests equal `req`, and the replay path is absent.

## Test plan
- `N_PLAYERS=4`, `N_ROUNDS=3`. Reset, pulse `cd_done`, press `req=4'b0100`, then release and pulse `w_done` -> `gnt_out=4'b0100`, `score[2]=1`, `round_out=1`, state back to COUNTDOWN.
- `req=4'b0110` in IDLE -> no grant and state stays IDLE. Then `req=4'b0010` -> `gnt_out=4'b0010`.
- Three rounds won by players 1, 3 and 1 -> GAME_END, `game_over_out=1`, `winner_idx_out=1`, scores 0,2,0,1.
- Tie 1-1-1 across players 0, 1 and 2 -> champion `winner_idx_out=0`.
- `ARB_FALSE_START_EN`: `req[0]` high during COUNTDOWN -> `dq_out=4'b0001`, and a later sole `req[0]` in IDLE gives no grant. All four players pressing -> round replayed with `round_out` unchanged.
- `rst_in_n` low during WINNER with `score[3]=2` -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/arbiter_game_fsm_multi_if.sv
// Signal bundle between the player buttons/timers and arbiter_game_fsm_multi.
// Handshake: a player holds req high; gnt_out stays up while that req is held,
// and release is the acknowledge that moves the round to WINNER.
// cd_done and w_done are strobes that are only looked at in COUNTDOWN and WINNER.
interface arbiter_game_fsm_multi_if #(
    parameter int N_PLAYERS = 4,
    parameter int N_ROUNDS  = 3
);
    localparam int IDX_W = $clog2(N_PLAYERS);
    localparam int SC_W  = $clog2(N_ROUNDS + 1);

    logic [N_PLAYERS-1:0]      req;
    logic                      cd_done;
    logic                      w_done;
    logic [N_PLAYERS-1:0]      gnt_out;
    logic                      cd_rst_out;
    logic                      w_rst_out;
    logic                      leds_rst_out;
    logic                      leds_sel_out;
    logic [IDX_W-1:0]          winner_idx_out;
    logic [SC_W-1:0]           round_out;
    logic [N_PLAYERS*SC_W-1:0] score_out;
    logic [N_PLAYERS-1:0]      dq_out;
    logic                      game_over_out;
    // Debug view of the FSM: 0 RESET, 1 COUNTDOWN, 2 IDLE, 3 GNT, 4 WINNER, 5 GAME_END.
    logic [2:0]                state_dbg_out;

    modport master (
        output req, cd_done, w_done,
        input  gnt_out, cd_rst_out, w_rst_out, leds_rst_out, leds_sel_out,
        input  winner_idx_out, round_out, score_out, dq_out, game_over_out,
        input  state_dbg_out
    );

    modport slave (
        input  req, cd_done, w_done,
        output gnt_out, cd_rst_out, w_rst_out, leds_rst_out, leds_sel_out,
        output winner_idx_out, round_out, score_out, dq_out, game_over_out,
        output state_dbg_out
    );
endinterface

// File: rtl/arbiter_game_fsm_multi.sv
// Multi-player, multi-round reaction-game controller with per-player scores.
// Optional false-start disqualification is compiled in with ARB_FALSE_START_EN.
module arbiter_game_fsm_multi #(
    parameter int N_PLAYERS = 4,
    parameter int N_ROUNDS  = 3
) (
    input logic                     clk,
    input logic                     rst_in_n,
    arbiter_game_fsm_multi_if.slave bus
);
    localparam int IDX_W = $clog2(N_PLAYERS);
    localparam int SC_W  = $clog2(N_ROUNDS + 1);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_IDLE      = 3'd2,
        S_GNT       = 3'd3,
        S_WINNER    = 3'd4,
        S_GAME_END  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, champ_q, sel_idx, champ_d;
    logic [N_PLAYERS-1:0] dq_q, masked;
    logic [SC_W-1:0]      score_q [N_PLAYERS];
    logic [SC_W-1:0]      round_q, round_inc, best;
    logic                 single, all_dq;
    logic                 ev_grant, ev_release, ev_round;
    logic                 cd_rst, w_rst, leds_rst, leds_sel, grant_ph;

`ifdef ARB_FALSE_START_EN
    assign masked = bus.req & ~dq_q;
    assign all_dq = &dq_q;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            dq_q <= '0;
        end else if (state_q == S_RESET) begin
            dq_q <= '0;
        end else if (state_q == S_COUNTDOWN) begin
            dq_q <= dq_q | bus.req;
        end
    end
`else
    assign masked = bus.req;
    assign all_dq = 1'b0;
    assign dq_q   = '0;
`endif

    // A tie (two or more simultaneous presses) is not a win for anyone.
    assign single    = (masked != '0) && ((masked & (masked - 1'b1)) == '0);
    assign round_inc = round_q + 1'b1;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (masked[i]) sel_idx = IDX_W'(i);
        end
    end

    // Strict compare keeps the lowest index on equal scores.
    always_comb begin
        champ_d = '0;
        best    = score_q[0];
        for (int i = 1; i < N_PLAYERS; i++) begin
            if (score_q[i] > best) begin
                best    = score_q[i];
                champ_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) state_q <= S_RESET;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ev_grant   = 1'b0;
        ev_release = 1'b0;
        ev_round   = 1'b0;
        cd_rst     = 1'b1;
        w_rst      = 1'b1;
        leds_rst   = 1'b1;
        leds_sel   = 1'b0;
        grant_ph   = 1'b0;
        case (state_q)
            S_RESET: state_d = S_COUNTDOWN;
            S_COUNTDOWN: begin
                cd_rst   = 1'b0;
                leds_rst = 1'b0;
                if (bus.cd_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (all_dq) begin
                    state_d = S_RESET;
                end else if (single) begin
                    state_d  = S_GNT;
                    ev_grant = 1'b1;
                end
            end
            S_GNT: begin
                w_rst    = 1'b0;
                leds_rst = 1'b0;
                leds_sel = 1'b1;
                grant_ph = 1'b1;
                if (!bus.req[idx_q]) begin
                    state_d    = S_WINNER;
                    ev_release = 1'b1;
                end
            end
            S_WINNER: begin
                w_rst    = 1'b0;
                leds_rst = 1'b0;
                leds_sel = 1'b1;
                grant_ph = 1'b1;
                if (bus.w_done) begin
                    ev_round = 1'b1;
                    state_d  = (round_inc == SC_W'(N_ROUNDS)) ? S_GAME_END : S_RESET;
                end
            end
            S_GAME_END: state_d = S_GAME_END;
            default:    state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            idx_q   <= '0;
            champ_q <= '0;
            round_q <= '0;
            for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
        end else begin
            if (state_q == S_RESET) idx_q <= '0;
            if (ev_grant)           idx_q <= sel_idx;
            if (ev_release)         score_q[idx_q] <= score_q[idx_q] + 1'b1;
            if (ev_round)           round_q <= round_inc;
            if (ev_round && state_d == S_GAME_END) champ_q <= champ_d;
        end
    end

    always_comb begin
        bus.winner_idx_out = '0;
        if (grant_ph)                      bus.winner_idx_out = idx_q;
        else if (state_q == S_GAME_END)    bus.winner_idx_out = champ_q;
    end

    always_comb begin
        bus.score_out = '0;
        for (int i = 0; i < N_PLAYERS; i++) bus.score_out[i*SC_W +: SC_W] = score_q[i];
    end

    assign bus.gnt_out       = grant_ph ? (N_PLAYERS'(1) << idx_q) : '0;
    assign bus.cd_rst_out    = cd_rst;
    assign bus.w_rst_out     = w_rst;
    assign bus.leds_rst_out  = leds_rst;
    assign bus.leds_sel_out  = leds_sel;
    assign bus.round_out     = round_q;
    assign bus.dq_out        = dq_q;
    assign bus.game_over_out = (state_q == S_GAME_END);
    assign bus.state_dbg_out = state_q;
endmodule
